// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv sequencing controller: state encoding,
// default pipeline/iteration depths and the start-acceptance decode.
package multdiv_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DIV_WAIT = 2'd1,
      DIV_RUN  = 2'd2,
      DIV_DONE = 2'd3
   } md_state_e;

   localparam int MULT_STAGES_DEF = 4;
   localparam int DIV_CYCLES_DEF  = 32;

   // A start pulse is only honoured while the divider is not busy.
   function automatic logic accepts_start(input md_state_e st);
      logic ok;
      case (st)
         IDLE:     ok = 1'b1;
         DIV_DONE: ok = 1'b1;
         DIV_WAIT: ok = 1'b0;
         DIV_RUN:  ok = 1'b0;
         default:  ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/multdiv_valid_pipe.sv
// Valid-bit shift register shadowing the free-running multiplier latch stages.
// Bit 0 is the first stage; the top bit marks a result leaving the pipe.
module multdiv_valid_pipe
   import multdiv_pkg::*;
#(
   parameter int STAGES = MULT_STAGES_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              shift_in,
   output logic [STAGES-1:0] valid
);

   logic [STAGES-1:0] valid_r;

   // Shift one stage per cycle; in-flight operations are dropped on reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_r <= {STAGES{1'b0}};
      end else begin
         valid_r <= (valid_r << 1) | STAGES'(shift_in);
      end
   end

   assign valid = valid_r;

endmodule

// File: rtl/multdiv_controller.sv
// Sequencing controller for the multdiv unit: tracks multiplies in flight,
// runs the iterative divider and drives the processor-facing handshake.
module multdiv_controller
   import multdiv_pkg::*;
#(
   parameter int MULT_STAGES = MULT_STAGES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = 6
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   ctrl_MULT,
   input  logic                   ctrl_DIV,
   input  logic                   div_by_zero,
   input  logic                   mult_overflow,
   output logic                   data_inputRDY,
   output logic                   op_latch_en,
   output logic [MULT_STAGES-1:0] mult_pipe_valid,
   output logic                   div_init,
   output logic                   div_step_en,
   output logic [CNT_W-1:0]       iter_count,
   output logic                   data_resultRDY,
   output logic                   data_exception,
   output logic                   result_sel_div
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_CYCLES - 1);
   localparam logic [CNT_W-1:0] ITER_ONE  = CNT_W'(1);

   md_state_e              state_r;
   md_state_e              state_next_s;
   logic                   rdy_s;
   logic                   mult_accept_s;
   logic                   div_accept_s;
   logic                   dz_r;
   logic [CNT_W-1:0]       iter_r;
   logic                   last_iter_s;
   logic [MULT_STAGES-1:0] pipe_shift_s;
   logic                   pipe_busy_s;
   logic                   pipe_drains_s;
   logic                   mult_result_s;

   assign rdy_s         = accepts_start(state_r);
   assign mult_accept_s = ctrl_MULT & rdy_s;
   // MULT has priority when both pulses arrive together.
   assign div_accept_s  = ctrl_DIV & ~ctrl_MULT & rdy_s;
   assign last_iter_s   = (iter_r == LAST_ITER);
   assign pipe_busy_s   = (mult_pipe_valid != {MULT_STAGES{1'b0}});
   // The pipe is empty next cycle once only the final stage (if any) is occupied.
   assign pipe_shift_s  = mult_pipe_valid << 1;
   assign pipe_drains_s = (pipe_shift_s == {MULT_STAGES{1'b0}});
   assign mult_result_s = mult_pipe_valid[MULT_STAGES-1];

   multdiv_valid_pipe #(
      .STAGES (MULT_STAGES)
   ) u_valid_pipe (
      .clock    (clock),
      .reset    (reset),
      .shift_in (mult_accept_s),
      .valid    (mult_pipe_valid)
   );

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Divide-by-zero flag captured with the accepted divide.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dz_r <= 1'b0;
      end else if (div_accept_s) begin
         dz_r <= div_by_zero;
      end else begin
         dz_r <= dz_r;
      end
   end

   // Divider iteration counter, wraps to zero when the run completes.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         iter_r <= {CNT_W{1'b0}};
      end else if (state_r == DIV_RUN && !last_iter_s) begin
         iter_r <= iter_r + ITER_ONE;
      end else begin
         iter_r <= {CNT_W{1'b0}};
      end
   end

   // Next-state decode.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE, DIV_DONE: begin
            if (!div_accept_s) begin
               state_next_s = IDLE;
            end else if (pipe_busy_s) begin
               state_next_s = DIV_WAIT;
            end else if (div_by_zero) begin
               state_next_s = DIV_DONE;
            end else begin
               state_next_s = DIV_RUN;
            end
         end
         DIV_WAIT: begin
            if (!pipe_drains_s) begin
               state_next_s = DIV_WAIT;
            end else if (dz_r) begin
               state_next_s = DIV_DONE;
            end else begin
               state_next_s = DIV_RUN;
            end
         end
         DIV_RUN: begin
            if (last_iter_s) begin
               state_next_s = DIV_DONE;
            end else begin
               state_next_s = DIV_RUN;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Output decode.
   always_comb begin
      data_inputRDY  = rdy_s;
      op_latch_en    = div_accept_s;
      iter_count     = iter_r;
      div_init       = 1'b0;
      div_step_en    = 1'b0;
      data_resultRDY = mult_result_s;
      data_exception = mult_result_s & mult_overflow;
      result_sel_div = 1'b0;
      case (state_r)
         DIV_RUN: begin
            div_step_en = 1'b1;
            div_init    = (iter_r == {CNT_W{1'b0}});
         end
         DIV_DONE: begin
            data_resultRDY = 1'b1;
            data_exception = dz_r;
            result_sel_div = 1'b1;
         end
         IDLE, DIV_WAIT: begin
            div_step_en = 1'b0;
         end
         default: begin
            div_step_en = 1'b0;
         end
      endcase
   end

endmodule
